// File: rtl/md_pkg.sv
// Purpose: shared op codes, FSM state encoding and op-class helper for the MD scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for ops that occupy the unit for multiple cycles (mult/div family).
    function automatic logic is_md_run(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// Purpose: request/response bundle between the E stage / hazard unit and the MD scheduler.
// Latency: n/a (wires only).
// Backpressure: stall_req tells the requester to hold start/op/a/b until accepted.
interface md_sched_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// Purpose: combinational multiply/divide result {res_hi,res_lo} for one MD op.
// Latency: 0 cycles (pure combinational; the scheduler adds the architectural delay).
// Backpressure: none.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo
);

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_signed_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_ua;
    logic [WIDTH-1:0]   w_ub;
    logic [WIDTH-1:0]   w_ub_safe;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;

    // Full-width products; explicit extension keeps both operands at 2*WIDTH.
    assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // Signed divide runs on magnitudes through the same unsigned divider as DIVU.
    assign w_signed_div = (i_op == MD_DIV);
    assign w_a_neg      = w_signed_div & i_a[WIDTH-1];
    assign w_b_neg      = w_signed_div & i_b[WIDTH-1];
    assign w_ua         = w_a_neg ? (~i_a + ONE) : i_a;
    assign w_ub         = w_b_neg ? (~i_b + ONE) : i_b;
    assign w_ub_safe    = (w_ub == '0) ? ONE : w_ub;
    assign w_uq         = w_ua / w_ub_safe;
    assign w_ur         = w_ua % w_ub_safe;

    // Select the result per op; divide-by-zero and INT_MIN/-1 take fixed values.
    always_comb begin
        o_res_hi = '0;
        o_res_lo = '0;
        case (i_op)
            MD_MULT: begin
                o_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                o_res_lo = w_prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                o_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                o_res_lo = w_prod_u[WIDTH-1:0];
            end
            MD_DIV, MD_DIVU: begin
                if (i_b == '0) begin
                    o_res_hi = i_a;
                    o_res_lo = ALL_ONES;
                end else if (w_signed_div && (i_a == INT_MIN) && (i_b == ALL_ONES)) begin
                    o_res_hi = '0;
                    o_res_lo = INT_MIN;
                end else begin
                    o_res_lo = (w_a_neg ^ w_b_neg) ? (~w_uq + ONE) : w_uq;
                    o_res_hi = w_a_neg ? (~w_ur + ONE) : w_ur;
                end
            end
            default: begin
                o_res_hi = '0;
                o_res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Purpose: multi-cycle MD scheduler; holds the result in shadow regs, then commits HI/LO.
// Latency: MULT_LAT / DIV_LAT cycles from accept edge to HI/LO update; MTHI/MTLO next edge.
// Backpressure: stall_req high while busy or a mult/div is requested; start while busy is ignored.
module md_sched
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    md_sched_if.slave md
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow_hi;
    logic [WIDTH-1:0] r_shadow_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_idle;
    logic             w_accept;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_commit;
    logic             w_busy;
    logic             w_done;
    logic             w_stall_req;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .i_op     (md.op),
        .i_a      (md.a),
        .i_b      (md.b),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo)
    );

    // flush beats any new request, including MTHI/MTLO; nothing is taken outside IDLE.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & md.start & ~md.flush & is_md_run(md.op);
    assign w_mthi   = w_idle & md.start & ~md.flush & (md.op == MD_MTHI);
    assign w_mtlo   = w_idle & md.start & ~md.flush & (md.op == MD_MTLO);
    assign w_commit = (r_state == ST_RUN) & (r_cnt == '0) & ~md.flush;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE->RUN on accept; RUN->IDLE on flush or when the count expires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (md.flush || (r_cnt == '0)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs to the hazard unit; no dependence on operand values.
    always_comb begin
        w_busy      = (r_state == ST_RUN);
        w_done      = w_commit;
        w_stall_req = w_busy | (md.start & is_md_run(md.op));
    end

    // Countdown, shadow capture on accept, and HI/LO update on commit or MTHI/MTLO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_shadow_hi <= '0;
            r_shadow_lo <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            if (w_accept) begin
                r_cnt       <= ((md.op == MD_DIV) || (md.op == MD_DIVU)) ? DIV_LOAD : MULT_LOAD;
                r_shadow_hi <= w_res_hi;
                r_shadow_lo <= w_res_lo;
            end else if ((r_state == ST_RUN) && (r_cnt != '0) && !md.flush) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (r_state == ST_RUN) begin
                r_cnt <= '0;
            end
            if (w_commit) begin
                r_hi <= r_shadow_hi;
                r_lo <= r_shadow_lo;
            end else begin
                if (w_mthi) r_hi <= md.a;
                if (w_mtlo) r_lo <= md.a;
            end
        end
    end

    assign md.busy      = w_busy;
    assign md.done      = w_done;
    assign md.stall_req = w_stall_req;
    assign md.hi        = r_hi;
    assign md.lo        = r_lo;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    md_sched_if #(.WIDTH(32)) md ();

    md_sched #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at the current negedge.
    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
    endtask

    // Called at a negedge after start dropped; measures busy cycles and done pulses.
    task automatic wait_idle(output int busy_cyc, output int done_cnt);
        busy_cyc = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (md.done === 1'b1) done_cnt++;
            if (md.busy !== 1'b1) break;
            busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        md.start = 1'b0; md.op = MD_MULT; md.a = '0; md.b = '0; md.flush = 1'b0;
        reset = 1'b0;
        #12;
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", md.busy); end
        n_cmp++; if (md.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", md.done); end
        n_cmp++; if (md.stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", md.stall_req); end
        n_cmp++; if ({md.hi, md.lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo got %h %h want 0 0", md.hi, md.lo); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bc, dc;
        present(op, a, b);
        #1;
        n_cmp++; if (md.stall_req !== 1'b1) begin n_err++; $display("FAIL %s_stall_at_req got %b want 1", name, md.stall_req); end
        @(negedge clk);
        md.start = 1'b0;
        wait_idle(bc, dc);
        n_cmp++; if (bc != lat) begin n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, lat); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL %s_done_count got %0d want 1", name, dc); end
        n_cmp++; if (md.hi !== exp_hi || md.lo !== exp_lo)
            begin n_err++; $display("FAIL %s_result got hi=%h lo=%h want hi=%h lo=%h", name, md.hi, md.lo, exp_hi, exp_lo); end
    endtask

    task automatic test_mult();
        run_op("mult",  MD_MULT,  32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    endtask

    task automatic test_div();
        run_op("div",      MD_DIV,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0", MD_DIVU, 32'd7,        32'd0,        10, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf",  MD_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    endtask

    task automatic test_mt();
        int bc, dc;
        // MTHI in IDLE: single-edge write, no stall, no busy, no done.
        present(MD_MTHI, 32'h00001234, 32'h0);
        #1;
        n_cmp++; if (md.stall_req !== 1'b0) begin n_err++; $display("FAIL mthi_stall got %b want 0", md.stall_req); end
        @(negedge clk);
        md.start = 1'b0;
        n_cmp++; if (md.hi !== 32'h00001234) begin n_err++; $display("FAIL mthi_hi got %h want 00001234", md.hi); end
        n_cmp++; if (md.busy !== 1'b0 || md.done !== 1'b0)
            begin n_err++; $display("FAIL mthi_busy_done got %b%b want 00", md.busy, md.done); end
        n_cmp++; if (md.lo !== 32'h80000000) begin n_err++; $display("FAIL mthi_lo_kept got %h want 80000000", md.lo); end
        // MULT 2*3, then MTLO held during RUN.
        present(MD_MULT, 32'd2, 32'd3);
        @(negedge clk);
        present(MD_MTLO, 32'h0000AAAA, 32'h0);
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            if (md.done === 1'b1) begin
                dc++;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL mtlo_run_done got %0d want 1", dc); end
        n_cmp++; if (md.lo !== 32'h80000000) begin n_err++; $display("FAIL mtlo_ignored_in_run got %h want 80000000", md.lo); end
        @(negedge clk);
        n_cmp++; if (md.lo !== 32'h00000006 || md.hi !== 32'h0)
            begin n_err++; $display("FAIL mtlo_commit got hi=%h lo=%h want 0 6", md.hi, md.lo); end
        @(negedge clk);
        md.start = 1'b0;
        n_cmp++; if (md.lo !== 32'h0000AAAA) begin n_err++; $display("FAIL mtlo_replay got %h want 0000AAAA", md.lo); end
        wait_idle(bc, dc);
        n_cmp++; if (bc != 0) begin n_err++; $display("FAIL mtlo_no_busy got %0d want 0", bc); end
    endtask

    task automatic test_flush();
        int dc;
        present(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        md.start = 1'b0;
        repeat (3) @(negedge clk);
        md.flush = 1'b1;
        @(negedge clk);
        md.flush = 1'b0;
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", md.busy); end
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (md.done === 1'b1) dc++;
            @(negedge clk);
        end
        n_cmp++; if (dc != 0) begin n_err++; $display("FAIL flush_no_done got %0d want 0", dc); end
        n_cmp++; if (md.hi !== 32'h0 || md.lo !== 32'h0000AAAA)
            begin n_err++; $display("FAIL flush_hilo got hi=%h lo=%h want 0 0000AAAA", md.hi, md.lo); end
        // flush together with a new MULT: not accepted.
        present(MD_MULT, 32'd5, 32'd5);
        md.flush = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        md.flush = 1'b0;
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got %b want 0", md.busy); end
        repeat (7) @(negedge clk);
        n_cmp++; if (md.hi !== 32'h0 || md.lo !== 32'h0000AAAA)
            begin n_err++; $display("FAIL flush_start_hilo got hi=%h lo=%h want 0 0000AAAA", md.hi, md.lo); end
    endtask

    task automatic test_back_to_back();
        int dc, stall_low, gap, cyc;
        logic seen_gap;
        present(MD_MULT, 32'd3, 32'd4);
        @(negedge clk);
        present(MD_DIV, 32'hFFFFFFEC, 32'd6);
        dc = 0; stall_low = 0; gap = 0; cyc = 0; seen_gap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc++;
            if (md.stall_req !== 1'b1) stall_low++;
            if (md.busy !== 1'b1) begin
                gap++;
                seen_gap = 1'b1;
                n_cmp++; if (md.hi !== 32'h0 || md.lo !== 32'h0000000C)
                    begin n_err++; $display("FAIL b2b_first_result got hi=%h lo=%h want 0 c", md.hi, md.lo); end
            end else if (seen_gap) begin
                md.start = 1'b0;
            end
            if (md.done === 1'b1) dc++;
            if (dc == 2) break;
            @(negedge clk);
        end
        md.start = 1'b0;
        @(negedge clk);
        n_cmp++; if (dc != 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", dc); end
        n_cmp++; if (stall_low != 0) begin n_err++; $display("FAIL b2b_stall_drop got %0d want 0", stall_low); end
        n_cmp++; if (gap != 1) begin n_err++; $display("FAIL b2b_idle_gap got %0d want 1", gap); end
        n_cmp++; if (cyc != 16) begin n_err++; $display("FAIL b2b_span got %0d want 16", cyc); end
        n_cmp++; if (md.hi !== 32'hFFFFFFFE || md.lo !== 32'hFFFFFFFD)
            begin n_err++; $display("FAIL b2b_final got hi=%h lo=%h want FFFFFFFE FFFFFFFD", md.hi, md.lo); end
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after got %b want 0", md.busy); end
    endtask

    task automatic test_reset_mid();
        int dc, bc;
        present(MD_MULT, 32'd7, 32'd9);
        @(negedge clk);
        md.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (md.hi !== 32'h0 || md.lo !== 32'h0)
            begin n_err++; $display("FAIL rst_mid_hilo got hi=%h lo=%h want 0 0", md.hi, md.lo); end
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", md.busy); end
        @(negedge clk);
        reset = 1'b1;
        dc = 0; bc = 0;
        for (int i = 0; i < 8; i++) begin
            if (md.done === 1'b1) dc++;
            if (md.busy === 1'b1) bc++;
            @(negedge clk);
        end
        n_cmp++; if (dc != 0 || bc != 0)
            begin n_err++; $display("FAIL rst_mid_after got done=%0d busy=%0d want 0 0", dc, bc); end
        n_cmp++; if (md.hi !== 32'h0 || md.lo !== 32'h0)
            begin n_err++; $display("FAIL rst_mid_final got hi=%h lo=%h want 0 0", md.hi, md.lo); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
